ifu_fetch: RTL and testbench

- Instruction-fetch stage and the consumer side of the next-PC path: holds the architectural PC, issues instruction-memory requests, and samples the next-PC value on each advance.
- Owns the IF/ID pipeline register, including the stall hold, bubble insertion and a one-entry buffer for instruction-memory returns that arrive while ID is stalled.
- Sits between the NPC logic / hazard unit and the ID stage of the 5-stage MIPS pipeline.

---
 rtl/ifu_fetch_pkg.sv | 17 +
 rtl/if_id_reg.sv | 61 ++++++
 rtl/ifu_fetch.sv | 94 +++++++++
 tb/tb_ifu_fetch.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage constants: reset PC, bubble encoding and the fetch FSM states.
package ifu_fetch_pkg;

  localparam logic [31:0] DefResetPc  = 32'h0000_3000;
  localparam logic [31:0] DefNopInstr = 32'h0000_0000;

  typedef enum logic {
    StReq = 1'b0,
    StBuf = 1'b1
  } fetch_state_e;

  // Fetch addresses are word aligned; the low two bits of any incoming target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
module if_id_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DefNopInstr
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_4_o,
  output logic        valid_o
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] pc_4_d, pc_4_q;
  logic        valid_d, valid_q;

  // A bubble keeps id_pc/id_pc_4 so only the instruction and valid bit change.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc_4_d  = pc_4_q;
    valid_d = valid_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      pc_4_d  = pc_4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      pc_4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc_4_q  <= pc_4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc_4_o  = pc_4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC register, imem request FSM, one-entry return buffer
// and control of the IF/ID register.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefResetPc,
  parameter logic [31:0] NOP_INSTR = DefNopInstr
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] next_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_4_o,
  output logic        id_valid_o
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  buf_d, buf_q;
  logic         advance;
  logic         id_bubble;
  logic [31:0]  id_instr_in;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    advance     = 1'b0;
    id_bubble   = flush_i;
    id_instr_in = imem_rdata_i;
    unique case (state_q)
      StReq: begin
        if (imem_rvalid_i && !stall_i) begin
          advance = 1'b1;
        end else if (imem_rvalid_i && stall_i) begin
          buf_d   = imem_rdata_i;
          state_d = StBuf;
        end else if (!stall_i) begin
          id_bubble = 1'b1;
        end
      end
      StBuf: begin
        id_instr_in = buf_q;
        if (!stall_i) begin
          advance = 1'b1;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
    pc_d = advance ? align_pc(next_pc_i) : pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Flush reaches IF/ID through the bubble input, which outranks load and hold.
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (advance),
    .bubble_i (id_bubble),
    .instr_i  (id_instr_in),
    .pc_i     (pc_q),
    .pc_4_i   (pc_q + 32'd4),
    .instr_o  (id_instr_o),
    .pc_o     (id_pc_o),
    .pc_4_o   (id_pc_4_o),
    .valid_o  (id_valid_o)
  );

  assign pc_o        = pc_q;
  assign imem_req_o  = (state_q == StReq);
  assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam logic [31:0] Nop     = 32'h0000_0000;
  localparam logic [31:0] Tag     = 32'hA5A5_0000;

  logic        clk, rst;
  logic [31:0] next_pc, rdata;
  logic        stall, flush, rvalid;
  logic [31:0] pc, imem_addr, id_instr, id_pc, id_pc_4;
  logic        imem_req, id_valid;

  int checks = 0;
  int errors = 0;

  // Model: architectural PC, a possibly held-back returned word, and the ID view.
  logic [31:0] m_pc, m_word, m_instr, m_id_pc, m_id_pc4;
  logic        m_holding, m_valid;

  ifu_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .next_pc_i     (next_pc),
    .stall_i       (stall),
    .flush_i       (flush),
    .pc_o          (pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc_4_o     (id_pc_4),
    .id_valid_o    (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = ResetPc; m_holding = 1'b0; m_word = Nop;
    m_instr = Nop; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock of the fetch stage, from the currently applied inputs.
  task automatic model_step();
    logic delivered;
    logic [31:0] word;
    delivered = !stall && (m_holding || rvalid);
    word      = m_holding ? m_word : rdata;
    if (flush) begin
      m_instr = Nop; m_valid = 1'b0;
    end else if (delivered) begin
      m_instr = word; m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end else if (!m_holding && !rvalid && !stall) begin
      m_instr = Nop; m_valid = 1'b0;
    end
    if (delivered) begin
      m_pc = {next_pc[31:2], 2'b00};
      m_holding = 1'b0;
    end else if (!m_holding && rvalid && stall) begin
      m_holding = 1'b1;
      m_word = rdata;
    end
  endtask

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_holding});
    chk("imem_addr", imem_addr, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_pc_4", id_pc_4, m_id_pc4);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
  end

  task automatic cyc(input logic rv, input logic [31:0] rd, input logic st, input logic fl,
                     input logic [31:0] np);
    @(negedge clk);
    rvalid = rv; rdata = rd; stall = st; flush = fl; next_pc = np;
    @(posedge clk);
    if (rvalid) chk("rvalid_only_with_req", {31'b0, imem_req}, 32'd1);
    model_step();
    #1;
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset_pc", pc, 32'h0000_3000);
    chk("async_reset_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    rvalid = 1'b0; stall = 1'b0; flush = 1'b0; next_pc = 32'h0; rdata = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk("post_reset_req", {31'b0, imem_req}, 32'd1);
    chk("post_reset_addr", imem_addr, 32'h0000_3000);
  endtask

  initial begin
    logic        rv, st, fl;
    logic [31:0] np;
    rst = 1'b1; rvalid = 1'b0; stall = 1'b0; flush = 1'b0; next_pc = 32'h0; rdata = 32'h0;
    model_reset();
    #12 rst = 1'b0;
    #1;
    chk("init_req", {31'b0, imem_req}, 32'd1);
    chk("init_addr", imem_addr, 32'h0000_3000);

    cyc(1'b1, 32'h3000 ^ Tag, 1'b0, 1'b0, 32'h3004);
    chk("stream_id_pc", id_pc, 32'h3000);
    chk("stream_id_instr", id_instr, 32'hA5A5_3000);
    chk("stream_pc", pc, 32'h3004);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h3008);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h3008);
    chk("wait_bubble_instr", id_instr, 32'h0);
    chk("wait_bubble_valid", {31'b0, id_valid}, 32'd0);
    chk("wait_addr_held", imem_addr, 32'h3004);
    cyc(1'b1, 32'h3004 ^ Tag, 1'b0, 1'b0, 32'h3008);
    chk("wait_delivered", id_instr, 32'hA5A5_3004);

    cyc(1'b1, 32'h3008 ^ Tag, 1'b1, 1'b0, 32'h300C);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300C);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300C);
    chk("stall_req_low", {31'b0, imem_req}, 32'd0);
    chk("stall_pc_held", pc, 32'h3008);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h300C);
    chk("unstall_instr", id_instr, 32'hA5A5_3008);
    chk("unstall_id_pc", id_pc, 32'h3008);
    chk("unstall_pc", pc, 32'h300C);

    cyc(1'b1, 32'h300C ^ Tag, 1'b0, 1'b1, 32'h3100);
    chk("flush_bubble", {31'b0, id_valid}, 32'd0);
    chk("flush_branch_addr", imem_addr, 32'h3100);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h3200);
    chk("flush_stall_bubble", {31'b0, id_valid}, 32'd0);
    chk("flush_stall_pc", pc, 32'h3100);

    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'hFFFF_FFFC);
    cyc(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_3103);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc_4", id_pc_4, 32'h0);
    chk("align_pc", pc, 32'h3100);

    mid_cycle_reset();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) mid_cycle_reset();
      rv = !m_holding && ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      np = ($urandom_range(0, 7) == 0) ? $urandom : m_pc + 32'd4;
      cyc(rv, $urandom, st, fl, np);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
